// File: rtl/vram_pkg.sv
// Shared constants for the VRAM arbiter: default widths, FSM state encoding and reset values.
`timescale 1ns/1ps
package vram_pkg;

  localparam int VRAM_AW = 14;
  localparam int VRAM_DW = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_V_ADDR = 3'd1;
  localparam logic [2:0] ST_V_CAP  = 3'd2;
  localparam logic [2:0] ST_C_ADDR = 3'd3;
  localparam logic [2:0] ST_C_CAP  = 3'd4;

  localparam logic        STROBE_RST    = 1'b0;
  localparam logic [15:0] DEFER_CNT_RST = 16'h0000;
  localparam logic [15:0] DEFER_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/vram_phase_timer.sv
// Tracks PixClock cycles since the last scanout request and opens the CPU window
// only while a 3-cycle CPU access cannot collide with the next fetch (GUARD >= 3).
`timescale 1ns/1ps
module vram_phase_timer #(
  parameter int VPERIOD = 16,
  parameter int GUARD   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic vreq,
  output logic cpu_window
);

  localparam int PW = (VPERIOD > 2) ? $clog2(VPERIOD) : 1;
  localparam logic [PW-1:0] PHASE_MAX = PW'(VPERIOD - 1);
  localparam logic [PW-1:0] WIN_END   = PW'(VPERIOD - GUARD);

  logic [PW-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (vreq) begin
      phase_d = '0;
    end else if (phase_q != PHASE_MAX) begin
      phase_d = phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign cpu_window = (phase_q < WIN_END);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout fetches always win, CPU accesses fill the safe slots.
// Define VRAM_ARB_STATS_EN to build the saturating scanout deferral counter on DEFER_CNT.
`timescale 1ns/1ps
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AW      = VRAM_AW,
  parameter int DW      = VRAM_DW,
  parameter int VPERIOD = 16,
  parameter int GUARD   = 4
) (
  input  logic          PixClock,
  input  logic          Reset,
  input  logic          VREQ,
  input  logic [AW-1:0] VADDR,
  output logic [DW-1:0] VDATA,
  output logic          VVALID,
  input  logic          CREQ,
  input  logic          CWE,
  input  logic [AW-1:0] CADDR,
  input  logic [DW-1:0] CWDATA,
  output logic [DW-1:0] CRDATA,
  output logic          CACK,
  output logic [AW-1:0] RAM_ADDR,
  output logic [DW-1:0] RAM_DO,
  output logic          RAM_WE,
  input  logic [DW-1:0] RAM_DI,
  output logic [15:0]   DEFER_CNT
);

  logic [2:0]    state_q, state_d;
  logic          vpend_q, vpend_d;
  logic [AW-1:0] vpend_addr_q, vpend_addr_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_do_q, ram_do_d;
  logic          ram_we_q, ram_we_d;
  logic [DW-1:0] vdata_q, vdata_d;
  logic          vvalid_q, vvalid_d;
  logic [DW-1:0] crdata_q, crdata_d;
  logic          cack_q, cack_d;
  logic          cpu_rd_q, cpu_rd_d;
  logic          cpu_window;
  logic          vreq_deferred;

  vram_phase_timer #(
    .VPERIOD (VPERIOD),
    .GUARD   (GUARD)
  ) u_phase_timer (
    .clk        (PixClock),
    .rst        (Reset),
    .vreq       (VREQ),
    .cpu_window (cpu_window)
  );

  assign vreq_deferred = VREQ && (state_q != ST_IDLE);

  // A fetch that lands mid-access is parked in vpend; the newest address replaces an older one.
  always_comb begin
    state_d      = state_q;
    vpend_d      = vpend_q;
    vpend_addr_d = vpend_addr_q;
    ram_addr_d   = ram_addr_q;
    ram_do_d     = ram_do_q;
    ram_we_d     = 1'b0;
    vdata_d      = vdata_q;
    vvalid_d     = 1'b0;
    crdata_d     = crdata_q;
    cack_d       = 1'b0;
    cpu_rd_d     = cpu_rd_q;

    if (vreq_deferred) begin
      vpend_d      = 1'b1;
      vpend_addr_d = VADDR;
    end

    case (state_q)
      ST_IDLE: begin
        if (VREQ || vpend_q) begin
          state_d    = ST_V_ADDR;
          ram_addr_d = VREQ ? VADDR : vpend_addr_q;
          vpend_d    = 1'b0;
        end else if (CREQ && cpu_window && !cack_q) begin
          // cack_q blocks a re-grant while the bridge is still lowering CREQ.
          state_d    = ST_C_ADDR;
          ram_addr_d = CADDR;
          ram_do_d   = CWDATA;
          ram_we_d   = CWE;
          cpu_rd_d   = !CWE;
        end
      end
      ST_V_ADDR: begin
        state_d = ST_V_CAP;
      end
      ST_V_CAP: begin
        vdata_d  = RAM_DI;
        vvalid_d = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_C_ADDR: begin
        state_d = ST_C_CAP;
      end
      ST_C_CAP: begin
        cack_d = 1'b1;
        if (cpu_rd_q) begin
          crdata_d = RAM_DI;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PixClock) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      vpend_q      <= 1'b0;
      vpend_addr_q <= '0;
      ram_addr_q   <= '0;
      ram_do_q     <= '0;
      ram_we_q     <= STROBE_RST;
      vdata_q      <= '0;
      vvalid_q     <= STROBE_RST;
      crdata_q     <= '0;
      cack_q       <= STROBE_RST;
      cpu_rd_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      vpend_q      <= vpend_d;
      vpend_addr_q <= vpend_addr_d;
      ram_addr_q   <= ram_addr_d;
      ram_do_q     <= ram_do_d;
      ram_we_q     <= ram_we_d;
      vdata_q      <= vdata_d;
      vvalid_q     <= vvalid_d;
      crdata_q     <= crdata_d;
      cack_q       <= cack_d;
      cpu_rd_q     <= cpu_rd_d;
    end
  end

  assign RAM_ADDR = ram_addr_q;
  assign RAM_DO   = ram_do_q;
  assign RAM_WE   = ram_we_q;
  assign VDATA    = vdata_q;
  assign VVALID   = vvalid_q;
  assign CRDATA   = crdata_q;
  assign CACK     = cack_q;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] defer_cnt_q, defer_cnt_d;

  always_comb begin
    defer_cnt_d = defer_cnt_q;
    if (vreq_deferred && (defer_cnt_q != DEFER_CNT_MAX)) begin
      defer_cnt_d = defer_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge PixClock) begin
    if (Reset) begin
      defer_cnt_q <= DEFER_CNT_RST;
    end else begin
      defer_cnt_q <= defer_cnt_d;
    end
  end

  assign DEFER_CNT = defer_cnt_q;
`else
  assign DEFER_CNT = DEFER_CNT_RST;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios then random scanout/CPU traffic against an occupancy-based reference model.
`timescale 1ns/1ps
module tb_vram_arbiter;

  localparam int AW      = 14;
  localparam int DW      = 8;
  localparam int VPERIOD = 16;
  localparam int GUARD   = 4;
  localparam int MAXC    = 8192;
  localparam int MEMSZ   = 16384;

  logic          PixClock = 1'b0;
  logic          Reset    = 1'b1;
  logic          VREQ     = 1'b0;
  logic [AW-1:0] VADDR    = '0;
  logic [DW-1:0] VDATA;
  logic          VVALID;
  logic          CREQ     = 1'b0;
  logic          CWE      = 1'b0;
  logic [AW-1:0] CADDR    = '0;
  logic [DW-1:0] CWDATA   = '0;
  logic [DW-1:0] CRDATA;
  logic          CACK;
  logic [AW-1:0] RAM_ADDR;
  logic [DW-1:0] RAM_DO;
  logic          RAM_WE;
  logic [DW-1:0] RAM_DI;
  logic [15:0]   DEFER_CNT;

  vram_arbiter #(
    .AW(AW), .DW(DW), .VPERIOD(VPERIOD), .GUARD(GUARD)
  ) dut (
    .PixClock (PixClock), .Reset (Reset),
    .VREQ (VREQ), .VADDR (VADDR), .VDATA (VDATA), .VVALID (VVALID),
    .CREQ (CREQ), .CWE (CWE), .CADDR (CADDR), .CWDATA (CWDATA),
    .CRDATA (CRDATA), .CACK (CACK),
    .RAM_ADDR (RAM_ADDR), .RAM_DO (RAM_DO), .RAM_WE (RAM_WE), .RAM_DI (RAM_DI),
    .DEFER_CNT (DEFER_CNT)
  );

  always #5 PixClock = ~PixClock;

  // Synchronous RAM macro stand-in: read data appears one cycle after the address.
  logic [DW-1:0] ram [MEMSZ];
  always @(posedge PixClock) begin
    if (RAM_WE) ram[RAM_ADDR] <= RAM_DO;
    RAM_DI <= ram[RAM_ADDR];
  end

  // Reference model: memory contents plus per-cycle expected events.
  logic [DW-1:0] ref_mem [MEMSZ];
  bit            exp_vv [MAXC];
  logic [DW-1:0] exp_vd [MAXC];
  bit            exp_ck [MAXC];
  bit            exp_rd [MAXC];
  logic [DW-1:0] exp_cd [MAXC];
  bit            exp_ca [MAXC];
  bit            exp_we [MAXC];
  logic [AW-1:0] exp_wa [MAXC];
  logic [DW-1:0] exp_wd [MAXC];
  int            cyc;
  int            free_at;
  int            last_v;
  bit            pend_v;
  logic [AW-1:0] pend_a;
  int            exp_defer;
  int            cpu_done;
  int            n_cmp;
  int            n_bad;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, want);
    end
  endtask

  function automatic int phaseAt(input int c);
    int p;
    p = c - last_v - 1;
    if (p > VPERIOD - 1) p = VPERIOD - 1;
    return p;
  endfunction

  function automatic logic [15:0] expDefer();
`ifdef VRAM_ARB_STATS_EN
    return 16'(exp_defer);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic modelReset();
    for (int i = cyc; i < MAXC; i++) begin
      exp_vv[i] = 1'b0; exp_ck[i] = 1'b0; exp_rd[i] = 1'b0;
      exp_ca[i] = 1'b0; exp_we[i] = 1'b0;
    end
    free_at   = cyc;
    last_v    = cyc - 1;
    pend_v    = 1'b0;
    exp_defer = 0;
    cpu_done  = -1;
  endtask

  // The RAM is busy for 3 cycles per access; video (fresh or parked) goes first when free.
  task automatic modelStep();
    int c;
    bit idle_now;
    logic [AW-1:0] a;
    c = cyc;
    idle_now = (c >= free_at);
    if (idle_now && (VREQ || pend_v)) begin
      a = VREQ ? VADDR : pend_a;
      pend_v = 1'b0;
      exp_vv[c+3] = 1'b1;
      exp_vd[c+3] = ref_mem[a];
      free_at = c + 3;
    end else if (VREQ) begin
      pend_v = 1'b1;
      pend_a = VADDR;
      if (exp_defer < 65535) exp_defer++;
    end else if (idle_now && CREQ && (phaseAt(c) < VPERIOD - GUARD) && !exp_ck[c]) begin
      exp_ca[c+1] = 1'b1;
      exp_we[c+1] = CWE;
      exp_wa[c+1] = CADDR;
      exp_wd[c+1] = CWDATA;
      exp_ck[c+3] = 1'b1;
      exp_rd[c+3] = !CWE;
      exp_cd[c+3] = ref_mem[CADDR];
      if (CWE) ref_mem[CADDR] = CWDATA;
      free_at  = c + 3;
      cpu_done = c + 3;
    end
    if (VREQ) last_v = c;
  endtask

  task automatic checkCycle();
    checkOutput("vvalid", VVALID, exp_vv[cyc]);
    if (exp_vv[cyc]) checkOutput("vdata", VDATA, exp_vd[cyc]);
    checkOutput("cack", CACK, exp_ck[cyc]);
    if (exp_ck[cyc] && exp_rd[cyc]) checkOutput("crdata", CRDATA, exp_cd[cyc]);
    checkOutput("ram_we", RAM_WE, exp_we[cyc]);
    if (exp_ca[cyc]) begin
      checkOutput("ram_addr", RAM_ADDR, exp_wa[cyc]);
      checkOutput("ram_do", RAM_DO, exp_wd[cyc]);
    end
    checkOutput("defer_cnt", DEFER_CNT, expDefer());
  endtask

  // Runs one PixClock cycle with the current inputs, then checks the new outputs.
  task automatic applyStimulus();
    bit was_reset;
    was_reset = Reset;
    if (!was_reset) modelStep();
    @(posedge PixClock);
    #1;
    cyc++;
    if (was_reset) begin
      modelReset();
      checkOutput("rst_vdata", VDATA, 0);
      checkOutput("rst_crdata", CRDATA, 0);
      checkOutput("rst_ram_addr", RAM_ADDR, 0);
      checkOutput("rst_ram_do", RAM_DO, 0);
    end
    checkCycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic vreqAt(input logic [AW-1:0] a);
    VREQ = 1'b1;
    VADDR = a;
    applyStimulus();
    VREQ = 1'b0;
  endtask

  task automatic cpuReq(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    CREQ = 1'b1;
    CWE = we;
    CADDR = a;
    CWDATA = d;
  endtask

  int  vcount;
  int  req_cyc;
  bit  hold_one;

  initial begin
    for (int i = 0; i < MEMSZ; i++) begin
      ram[i]     = 8'((i * 7 + 3) ^ (i >> 8));
      ref_mem[i] = 8'((i * 7 + 3) ^ (i >> 8));
    end
    ram[14'h0123]     = 8'hA5;
    ref_mem[14'h0123] = 8'hA5;
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    modelReset();

    Reset = 1'b1;
    idle(3);
    Reset = 1'b0;

    $display("[TB] scanout only");
    for (int k = 0; k < 3; k++) begin
      vreqAt(14'h0123);
      idle(2);
      checkOutput("scan_vvalid", VVALID, 1);
      checkOutput("scan_vdata", VDATA, 8'hA5);
      idle(13);
    end

    $display("[TB] cpu write in open window");
    vreqAt(14'h0123);
    idle(2);
    cpuReq(1'b1, 14'h2000, 8'h5A);
    idle(1);
    checkOutput("wr_we", RAM_WE, 1);
    checkOutput("wr_addr", RAM_ADDR, 14'h2000);
    checkOutput("wr_do", RAM_DO, 8'h5A);
    idle(1);
    checkOutput("wr_we_len", RAM_WE, 0);
    idle(1);
    checkOutput("wr_cack", CACK, 1);
    CREQ = 1'b0;
    idle(10);
    vreqAt(14'h2000);
    idle(2);
    checkOutput("wr_readback", VDATA, 8'h5A);

    $display("[TB] guard window");
    idle(11);
    cpuReq(1'b0, 14'h0123, 8'h00);
    idle(2);
    vreqAt(14'h0040);
    idle(2);
    checkOutput("guard_vvalid", VVALID, 1);
    idle(3);
    checkOutput("guard_cack", CACK, 1);
    checkOutput("guard_crdata", CRDATA, 8'hA5);
    CREQ = 1'b0;
    idle(10);

    $display("[TB] collision");
    cpuReq(1'b0, 14'h2000, 8'h00);
    vreqAt(14'h0123);
    idle(2);
    checkOutput("col_vvalid", VVALID, 1);
    checkOutput("col_vdata", VDATA, 8'hA5);
    idle(3);
    checkOutput("col_cack", CACK, 1);
    checkOutput("col_crdata", CRDATA, 8'h5A);
    CREQ = 1'b0;

    $display("[TB] deferral");
    idle(6);
    cpuReq(1'b1, 14'h0300, 8'hC3);
    idle(1);
    vreqAt(14'h0123);
    idle(1);
    checkOutput("def_cack", CACK, 1);
    CREQ = 1'b0;
    idle(3);
    checkOutput("def_vvalid", VVALID, 1);
    checkOutput("def_vdata", VDATA, 8'hA5);
`ifdef VRAM_ARB_STATS_EN
    checkOutput("def_count", DEFER_CNT, 1);
`else
    checkOutput("def_count", DEFER_CNT, 0);
`endif

    $display("[TB] reset mid-write");
    cpuReq(1'b1, 14'h0500, 8'h77);
    idle(1);
    checkOutput("rmw_we", RAM_WE, 1);
    Reset = 1'b1;
    CREQ = 1'b0;
    CWE = 1'b0;
    idle(1);
    checkOutput("rmw_we_off", RAM_WE, 0);
    checkOutput("rmw_cack", CACK, 0);
    checkOutput("rmw_defer", DEFER_CNT, 0);
    Reset = 1'b0;
    vreqAt(14'h0123);
    idle(2);
    checkOutput("rmw_idle_vvalid", VVALID, 1);
    checkOutput("rmw_idle_vdata", VDATA, 8'hA5);
    idle(5);

    $display("[TB] random traffic");
    vcount = 0;
    req_cyc = 0;
    hold_one = 1'b0;
    cpu_done = -1;
    while (cyc < 3800) begin
      if (vcount == 0) begin
        VREQ = 1'b1;
        vcount = 14 + int'($urandom_range(0, 3));
      end else begin
        VREQ = ($urandom_range(0, 29) == 0);
        vcount--;
      end
      VADDR = AW'($urandom_range(0, MEMSZ - 1));
      if (CREQ) begin
        if (CACK) begin
          if ($urandom_range(0, 1) == 0) CREQ = 1'b0;
          else hold_one = 1'b1;
        end else if (hold_one) begin
          CREQ = 1'b0;
          hold_one = 1'b0;
        end else if ($urandom_range(0, 24) == 0) begin
          CREQ = 1'b0;
        end
      end else if ((cyc > cpu_done) && ($urandom_range(0, 3) == 0)) begin
        cpuReq(1'($urandom_range(0, 1)), AW'($urandom_range(0, MEMSZ - 1)),
               DW'($urandom_range(0, 255)));
        req_cyc = cyc;
      end
      applyStimulus();
    end

    VREQ = 1'b0;
    CREQ = 1'b0;
    idle(8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port 16K x 8 video RAM between the raster scanout fetch and the CPU bus bridge.
- Scanout reads always take priority.
- CPU byte reads and writes are granted only in slots that cannot delay the next scanout fetch.
- Sits between the video timing block (PIXADDR/PIXDATA side) and the RAM macro, all in the PixClock domain.

Parameters:
- AW, 14, RAM address width.
- DW, 8, RAM data width.
- VPERIOD, 16, nominal PixClock cycles between scanout fetch requests.
- GUARD, 4, cycles before the expected scanout request during which no CPU grant is issued (must satisfy GUARD >= 3).

Ports:
- PixClock  in  1  sole clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- VREQ  in  1  one-cycle scanout fetch pulse.
- VADDR  in  AW  scanout address, valid with VREQ.
- VDATA  out  DW  scanout read data.
- VVALID  out  1  one-cycle pulse, VDATA valid.
- CREQ  in  1  CPU request level, held until CACK.
- CWE  in  1  1 = write, 0 = read; stable while CREQ.
- CADDR  in  AW  CPU address; stable while CREQ.
- CWDATA  in  DW  CPU write data.
- CRDATA  out  DW  CPU read data, valid with CACK on reads.
- CACK  out  1  one-cycle completion pulse.
- RAM_ADDR  out  AW  registered RAM address.
- RAM_DO  out  DW  registered RAM write data.
- RAM_WE  out  1  registered RAM write strobe.
- RAM_DI  in  DW  RAM read data; synchronous RAM, valid one cycle after RAM_ADDR.
- DEFER_CNT  out  16  scanout deferral count (see Optional Feature).

Behaviour:
- Reset: state IDLE; VDATA, CRDATA, RAM_ADDR, RAM_DO = 0; VVALID, CACK, RAM_WE = 0; phase counter = 0; vpend = 0.
- Phase counter:
  - Cleared on every VREQ; otherwise increments, saturating at VPERIOD-1.
  - CPU window is open when phase < VPERIOD-GUARD.
- States: IDLE, V_ADDR, V_CAP, C_ADDR, C_CAP.
- IDLE:
  - VREQ or vpend → V_ADDR; RAM_ADDR <= VADDR (or the latched address when vpend); clear vpend.
  - Else CREQ and window open → C_ADDR; RAM_ADDR <= CADDR; RAM_DO <= CWDATA; RAM_WE <= CWE.
  - Same-cycle VREQ and CREQ: video wins; CREQ keeps waiting.
- V_ADDR → V_CAP unconditionally.
- V_CAP: VDATA <= RAM_DI; VVALID pulses for one cycle; → IDLE.
  - Latency VREQ → VVALID is exactly 3 cycles when IDLE at VREQ.
- C_ADDR: RAM_WE cleared (write strobe is exactly one cycle); → C_CAP.
- C_CAP: CACK pulses; on reads CRDATA <= RAM_DI; → IDLE.
  - CPU sees CACK 3 cycles after grant for both reads and writes.
- VREQ arriving in any non-IDLE state: VADDR latched into vpend.
  - Serviced on the next IDLE cycle ahead of the CPU; worst-case latency 5 cycles.
  - A second VREQ while vpend is set overwrites the latched address (the newest fetch wins).
- CREQ dropped before grant: no access occurs. CREQ dropped after grant: the access completes and CACK still pulses; the bridge ignores it.
- CACK suppression: CREQ must fall the cycle after CACK. The arbiter does not re-grant in the cycle immediately following CACK.
- Reset mid-access: cycle aborted immediately; RAM_WE forced 0; no CACK or VVALID emitted.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- With it: DEFER_CNT is a 16-bit saturating counter.
  - Increments on each VREQ that is set pending (VREQ not seen in IDLE).
  - Cleared by Reset.
  - Saturates at 16'hFFFF.
- Without it: DEFER_CNT tied to 0 and no counter logic is generated.

Decomposition:
- Shared package vram_pkg:
  - State encoding constants (IDLE=0, V_ADDR=1, V_CAP=2, C_ADDR=3, C_CAP=4).
  - Default AW/DW.
  - Reset value constants.
- Sub-module vram_phase_timer: phase counter plus window compare, parameterised by VPERIOD/GUARD, output cpu_window.
- FSM, capture registers and vpend remain in vram_arbiter.

Test Plan:
- Scanout only: VREQ every 16 cycles, VADDR=14'h0123, RAM holds 8'hA5 there → VVALID exactly 3 cycles after each VREQ, VDATA=8'hA5, RAM_WE never high.
- CPU write in open window: CREQ=1, CWE=1, CADDR=14'h2000, CWDATA=8'h5A at phase 2 → RAM_WE high one cycle with RAM_ADDR=14'h2000, RAM_DO=8'h5A; CACK 3 cycles after grant; a following scanout read of 14'h2000 returns 8'h5A.
- Guard window: CREQ asserted at phase 13 (VPERIOD=16, GUARD=4) → no grant until after the next VREQ service; grant in the first IDLE cycle after VVALID.
- Collision: VREQ and CREQ in same IDLE cycle → video serviced first (VVALID at +3); CPU granted next, CACK at +6.
- Deferral: force CPU grant at phase 11 with a VREQ forced 1 cycle later → vpend set; VVALID at VREQ+5; with VRAM_ARB_STATS_EN, DEFER_CNT=1.
- Reset mid-write: assert Reset in C_ADDR → RAM_WE=0 the next cycle; CACK, VVALID and DEFER_CNT all 0; state IDLE.
